exec_unit: RTL and testbench



---
 rtl/exec_unit.sv | 152 +++++++++++++++
 tb/tb_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: execute-stage controller placed in front of an 8-bit ALU.
// It holds the operand registers A and B. Instructions arrive one at a time
// over a valid/ready handshake. The ALU inputs are driven from A, B and the
// latched instruction, and the ALU result is written back to A or B while
// the zero and negative flags are updated. A three-state FSM (IDLE, EXEC, WB)
// sequences each instruction, so the block retires at most one instruction
// every three cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid, in_ready  instruction handshake; instr is sampled when both are 1
//   instr[13:0]         {kind[1:0], dst, sel[2:0], imm[7:0]}
//   alu_a, alu_b, alu_s operands and select driven to the ALU
//   alu_out             combinational ALU result
//   reg_a, reg_b        current A and B registers
//   flag_z, flag_n      zero / negative flags of the last written result
//   done                one-cycle pulse when an instruction retires
module exec_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [13:0]  instr,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_s,
    input  logic [W-1:0] alu_out,
    output logic [W-1:0] reg_a,
    output logic [W-1:0] reg_b,
    output logic         flag_z,
    output logic         flag_n,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] KIND_RR  = 2'b00;
    localparam logic [1:0] KIND_LDI = 2'b01;
    localparam logic [1:0] KIND_RI  = 2'b10;
    localparam logic [1:0] KIND_NOP = 2'b11;

    state_t       state, state_nxt;
    logic [13:0]  ir;
    logic [W-1:0] res;
    logic [W-1:0] a_q, b_q;
    logic         z_q, n_q, done_q;

    logic [1:0]   kind;
    logic         dst;
    logic [W-1:0] imm_ext;

    function automatic logic zero_of(input logic [W-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic neg_of(input logic [W-1:0] v);
        return v[W-1];
    endfunction

    assign kind    = ir[13:12];
    assign dst     = ir[11];
    assign imm_ext = W'(ir[7:0]);

    // ALU drive is purely combinational from the latched instruction, so it
    // is stable for the whole EXEC cycle in which RES is captured.
    assign alu_a = a_q;
    assign alu_b = (kind == KIND_RI) ? imm_ext : b_q;
    assign alu_s = ir[10:8];

    assign reg_a  = a_q;
    assign reg_b  = b_q;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign done   = done_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: instruction latch, result capture, write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir     <= '0;
            res    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ir <= instr;
                    end
                end
                EXEC: begin
                    // RES holds the pre-write operands' result, so A <= A op B
                    // sees the old A.
                    case (kind)
                        KIND_RR, KIND_RI: res <= alu_out;
                        KIND_LDI:         res <= imm_ext;
                        default:          res <= res;
                    endcase
                end
                WB: begin
                    done_q <= 1'b1;
                    if (kind != KIND_NOP) begin
                        if (dst) begin
                            b_q <= res;
                        end else begin
                            a_q <= res;
                        end
                        z_q <= zero_of(res);
                        n_q <= neg_of(res);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural 8-bit ALU attached.
module tb_exec_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [13:0]  instr;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_s;
    logic [W-1:0] alu_out;
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;
    logic         flag_z;
    logic         flag_n;
    logic         done;

    int n_chk  = 0;
    int n_fail = 0;

    exec_unit #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_out  (alu_out),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        alu_out = '0;
        case (alu_s)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a ^ alu_b;
            3'b101:  alu_out = ~alu_a;
            3'b110:  alu_out = alu_a << 1;
            default: alu_out = alu_a >> 1;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction, wait for its retirement, check latency.
    // Returns at the falling edge where done is first seen high.
    task automatic run_instr(input logic [13:0] ins, input string tag);
        bit acc;
        int lat;
        @(negedge clk);
        instr    = ins;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        chk({tag, " accepted"}, 16'(acc), 16'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 8);
        chk({tag, " done_lat"}, 16'(lat), 16'd3);
    endtask

    // Instruction encodings: {kind, dst, sel, imm}
    function automatic logic [13:0] ldi(input logic d, input logic [7:0] v);
        return {2'b01, d, 3'b000, v};
    endfunction
    function automatic logic [13:0] alu_rr(input logic d, input logic [2:0] s);
        return {2'b00, d, s, 8'h00};
    endfunction
    function automatic logic [13:0] alu_ri(input logic d, input logic [2:0] s, input logic [7:0] v);
        return {2'b10, d, s, v};
    endfunction

    logic [13:0] q [4];
    int          idx;
    int          dcnt;
    logic        rdy;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        repeat (2) @(negedge clk);
        chk("rst reg_a", 16'(reg_a), 16'h00);
        chk("rst reg_b", 16'(reg_b), 16'h00);
        chk("rst flags", 16'({flag_z, flag_n}), 16'h0);
        chk("rst done", 16'(done), 16'h0);
        chk("rst in_ready", 16'(in_ready), 16'h1);
        chk("rst alu_drive", 16'({alu_s, alu_a, alu_b}), 16'h0);
        rst_n = 1'b1;

        // LDI A,5; LDI B,3; ADD -> A
        run_instr(ldi(1'b0, 8'h05), "ldi a5");
        run_instr(ldi(1'b1, 8'h03), "ldi b3");
        run_instr(alu_rr(1'b0, 3'b000), "add a");
        chk("t1 reg_a", 16'(reg_a), 16'h08);
        chk("t1 reg_b", 16'(reg_b), 16'h03);
        chk("t1 z,n", 16'({flag_z, flag_n}), 16'h0);
        @(negedge clk);
        chk("t1 done clears", 16'(done), 16'h0);

        // LDI A,FF; LDI B,01; ADD -> B wraps to 0
        run_instr(ldi(1'b0, 8'hFF), "ldi aff");
        chk("ldi ff n", 16'({flag_z, flag_n}), 16'h1);
        run_instr(ldi(1'b1, 8'h01), "ldi b1");
        run_instr(alu_rr(1'b1, 3'b000), "add b");
        chk("t2 reg_b", 16'(reg_b), 16'h00);
        chk("t2 reg_a", 16'(reg_a), 16'hFF);
        chk("t2 z,n", 16'({flag_z, flag_n}), 16'h2);

        // NOP keeps flags and registers
        run_instr({2'b11, 1'b0, 3'b000, 8'h00}, "nop");
        chk("nop z,n", 16'({flag_z, flag_n}), 16'h2);
        chk("nop regs", 16'({reg_a, reg_b}), 16'hFF00);

        // LDI A,1; OR imm 0x80 -> A; SHR1 -> A
        run_instr(ldi(1'b0, 8'h01), "ldi a1");
        run_instr(alu_ri(1'b0, 3'b011, 8'h80), "ori a");
        chk("t3 reg_a", 16'(reg_a), 16'h81);
        chk("t3 z,n", 16'({flag_z, flag_n}), 16'h1);
        run_instr(alu_rr(1'b0, 3'b111), "shr a");
        chk("t3 shr reg_a", 16'(reg_a), 16'h40);
        chk("t3 shr z,n", 16'({flag_z, flag_n}), 16'h0);

        // Back-to-back with in_valid held high
        q[0] = ldi(1'b0, 8'h10);
        q[1] = ldi(1'b1, 8'h20);
        q[2] = alu_rr(1'b0, 3'b000);
        q[3] = alu_rr(1'b1, 3'b001);
        idx  = 0;
        dcnt = 0;
        @(negedge clk);
        instr    = q[0];
        in_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) @(negedge clk);
            rdy = in_ready;
            if (done) dcnt++;
            chk($sformatf("b2b ready[%0d]", i), 16'(rdy), 16'((i % 3) == 0));
            @(posedge clk);
            #1;
            if (rdy && in_valid) begin
                idx++;
                if (idx < 4) instr = q[idx];
                else in_valid = 1'b0;
            end
        end
        chk("b2b accepted", 16'(idx), 16'd4);
        chk("b2b done count", 16'(dcnt), 16'd4);
        chk("b2b reg_a", 16'(reg_a), 16'h30);
        chk("b2b reg_b", 16'(reg_b), 16'h10);

        // Reset during EXEC of ADD
        @(negedge clk);
        instr    = alu_rr(1'b0, 3'b000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid regs", 16'({reg_a, reg_b}), 16'h0000);
        chk("rst mid flags", 16'({flag_z, flag_n}), 16'h0);
        chk("rst mid done", 16'(done), 16'h0);
        chk("rst mid in_ready", 16'(in_ready), 16'h1);
        repeat (2) @(negedge clk);
        chk("rst hold done", 16'(done), 16'h0);
        rst_n = 1'b1;
        run_instr(ldi(1'b0, 8'h07), "post ldi");
        chk("post reg_a", 16'(reg_a), 16'h07);
        run_instr(alu_rr(1'b1, 3'b100), "post xor b");
        chk("post reg_b", 16'(reg_b), 16'h07);
        chk("post z,n", 16'({flag_z, flag_n}), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
